// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: captures I-cache and D-cache request pulses, grants
// the external 64-bit bus round-robin, assembles multi-beat reads into a full
// cache line and forwards single-beat writes, answering each with a one-cycle
// completion pulse to the owning cache.
module mem_arbiter #(
  parameter int WIDTH       = 64,
  parameter int BLOCKSZ     = 512,
  parameter int BEATS       = 8,
  parameter int ADDRESSSIZE = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  // I-cache port
  input  logic                   ic_mem_req,
  input  logic [ADDRESSSIZE-1:0] ic_mem_address,
  input  logic                   ic_mem_wr_en,
  input  logic [WIDTH-1:0]       ic_mem_data_out,
  output logic [BLOCKSZ-1:0]     ic_mem_data_in,
  output logic                   ic_mem_data_valid,
  // D-cache port
  input  logic                   dc_mem_req,
  input  logic [ADDRESSSIZE-1:0] dc_mem_address,
  input  logic                   dc_mem_wr_en,
  input  logic [WIDTH-1:0]       dc_mem_data_out,
  output logic [BLOCKSZ-1:0]     dc_mem_data_in,
  output logic                   dc_mem_data_valid,
  // External bus
  output logic                   bus_req,
  output logic [ADDRESSSIZE-1:0] bus_addr,
  output logic                   bus_wr,
  output logic [WIDTH-1:0]       bus_wdata,
  input  logic                   bus_ready,
  input  logic [WIDTH-1:0]       bus_rdata,
  input  logic                   bus_rvalid,
  input  logic                   bus_wack
);

  localparam int            BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RDATA,
    S_WACK,
    S_RESPOND
  } state_t;

  state_t                   state_q, state_d;
  logic                     owner_q, owner_d;           // 0 = I-cache, 1 = D-cache
  logic                     last_grant_q, last_grant_d; // port served most recently
  logic [BW-1:0]            beat_q, beat_d;
  logic [BLOCKSZ-1:0]       line_q, line_d;
  logic [ADDRESSSIZE-1:0]   bus_addr_q, bus_addr_d;
  logic                     bus_wr_q, bus_wr_d;
  logic [WIDTH-1:0]         bus_wdata_q, bus_wdata_d;

  // Port-indexed views of the raw request inputs
  logic [1:0]               req_w;
  logic [1:0]               wr_en_w;
  logic [ADDRESSSIZE-1:0]   req_addr_w  [2];
  logic [WIDTH-1:0]         req_wdata_w [2];

  // Port-indexed views of the capture registers
  logic [1:0]               pend_w;
  logic [1:0]               wr_w;
  logic [ADDRESSSIZE-1:0]   addr_w    [2];
  logic [WIDTH-1:0]         wdata_w   [2];
  logic [BLOCKSZ-1:0]       data_in_w [2];
  logic [1:0]               done_w;
  logic                     load_line_w;

  assign req_w          = {dc_mem_req, ic_mem_req};
  assign wr_en_w        = {dc_mem_wr_en, ic_mem_wr_en};
  assign req_addr_w[0]  = ic_mem_address;
  assign req_addr_w[1]  = dc_mem_address;
  assign req_wdata_w[0] = ic_mem_data_out;
  assign req_wdata_w[1] = dc_mem_data_out;

  // The final beat is merged on the fly so the owner sees the full line in RESPOND
  assign load_line_w = (state_q == S_RDATA) && bus_rvalid && (beat_q == LAST_BEAT);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic                   pend_q;
      logic                   wr_q;
      logic [ADDRESSSIZE-1:0] addr_q;
      logic [WIDTH-1:0]       wdata_q;
      logic [BLOCKSZ-1:0]     data_in_q;
      logic                   mine_w;

      assign mine_w     = (owner_q == 1'(gi));
      assign done_w[gi] = (state_q == S_RESPOND) && mine_w;

      // Capture one outstanding request; a request on the completing edge re-arms
      always_ff @(posedge clk) begin
        if (rst) begin
          pend_q    <= 1'b0;
          wr_q      <= 1'b0;
          addr_q    <= '0;
          wdata_q   <= '0;
          data_in_q <= '0;
        end else begin
          if (req_w[gi] && (!pend_q || done_w[gi])) begin
            pend_q  <= 1'b1;
            addr_q  <= req_addr_w[gi];
            wr_q    <= wr_en_w[gi];
            wdata_q <= req_wdata_w[gi];
          end else if (done_w[gi]) begin
            pend_q  <= 1'b0;
          end
          if (load_line_w && mine_w) begin
            data_in_q <= line_d;
          end
        end
      end

      assign pend_w[gi]    = pend_q;
      assign wr_w[gi]      = wr_q;
      assign addr_w[gi]    = addr_q;
      assign wdata_w[gi]   = wdata_q;
      assign data_in_w[gi] = data_in_q;
    end
  endgenerate

  // Arbiter state, beat counter, line buffer and registered bus request fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_q       <= '0;
      line_q       <= '0;
      bus_addr_q   <= '0;
      bus_wr_q     <= 1'b0;
      bus_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
      line_q       <= line_d;
      bus_addr_q   <= bus_addr_d;
      bus_wr_q     <= bus_wr_d;
      bus_wdata_q  <= bus_wdata_d;
    end
  end

  // Next-state: grant in IDLE, handshake in ISSUE, collect beats or wait for ack
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    line_d       = line_q;
    bus_addr_d   = bus_addr_q;
    bus_wr_d     = bus_wr_q;
    bus_wdata_d  = bus_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (|pend_w) begin
          // On a tie the port that was not served last wins
          owner_d     = (&pend_w) ? ~last_grant_q : pend_w[1];
          state_d     = S_ISSUE;
          bus_wr_d    = wr_w[owner_d];
          bus_wdata_d = wdata_w[owner_d];
          // Reads fetch the whole aligned line; writes go to the exact address
          bus_addr_d  = wr_w[owner_d] ? addr_w[owner_d]
                                      : {addr_w[owner_d][ADDRESSSIZE-1:6], 6'b0};
        end
      end
      S_ISSUE: begin
        if (bus_ready) begin
          beat_d  = '0;
          state_d = bus_wr_q ? S_WACK : S_RDATA;
        end
      end
      S_RDATA: begin
        if (bus_rvalid) begin
          line_d[beat_q*WIDTH +: WIDTH] = bus_rdata;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = S_RESPOND;
          end
        end
      end
      S_WACK: begin
        if (bus_wack) begin
          state_d = S_RESPOND;
        end
      end
      S_RESPOND: begin
        last_grant_d = owner_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus_req           = (state_q == S_ISSUE);
  assign bus_addr          = bus_addr_q;
  assign bus_wr            = bus_wr_q;
  assign bus_wdata         = bus_wdata_q;
  assign ic_mem_data_in    = data_in_w[0];
  assign ic_mem_data_valid = done_w[0];
  assign dc_mem_data_in    = data_in_w[1];
  assign dc_mem_data_valid = done_w[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a transaction-level
// reference model of pending requests, round-robin order and returned lines.
module tb_mem_arbiter;

  localparam int W = 64;
  localparam int B = 512;
  localparam int N = 8;
  localparam int A = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ic_mem_req = 1'b0, dc_mem_req = 1'b0;
  logic [A-1:0]  ic_mem_address = '0, dc_mem_address = '0;
  logic          ic_mem_wr_en = 1'b0, dc_mem_wr_en = 1'b0;
  logic [W-1:0]  ic_mem_data_out = '0, dc_mem_data_out = '0;
  logic [B-1:0]  ic_mem_data_in, dc_mem_data_in;
  logic          ic_mem_data_valid, dc_mem_data_valid;
  logic          bus_req, bus_wr;
  logic [A-1:0]  bus_addr;
  logic [W-1:0]  bus_wdata;
  logic          bus_ready = 1'b0, bus_rvalid = 1'b0, bus_wack = 1'b0;
  logic [W-1:0]  bus_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(W), .BLOCKSZ(B), .BEATS(N), .ADDRESSSIZE(A)) dut (
    .clk(clk), .rst(rst),
    .ic_mem_req(ic_mem_req), .ic_mem_address(ic_mem_address), .ic_mem_wr_en(ic_mem_wr_en),
    .ic_mem_data_out(ic_mem_data_out), .ic_mem_data_in(ic_mem_data_in),
    .ic_mem_data_valid(ic_mem_data_valid),
    .dc_mem_req(dc_mem_req), .dc_mem_address(dc_mem_address), .dc_mem_wr_en(dc_mem_wr_en),
    .dc_mem_data_out(dc_mem_data_out), .dc_mem_data_in(dc_mem_data_in),
    .dc_mem_data_valid(dc_mem_data_valid),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .bus_wack(bus_wack)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ic_vcnt = 0, dc_vcnt = 0, issues = 0;
  logic prev_req = 1'b0;

  // Reference model: one outstanding request per port, last served port,
  // expected contents of each port's returned line, completions per port.
  logic         m_pend  [2];
  logic [A-1:0] m_addr  [2];
  logic         m_wr    [2];
  logic [W-1:0] m_wdata [2];
  logic [B-1:0] m_data  [2];
  int           m_done  [2];
  int           m_last;

  task automatic check_val(input string tag, input logic [B-1:0] got, input logic [B-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock and observe just after the edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (ic_mem_data_valid) ic_vcnt++;
    if (dc_mem_data_valid) dc_vcnt++;
    if (bus_req && !prev_req) issues++;
    prev_req = bus_req;
  endtask

  function automatic logic valid_of(input int p);
    return (p == 0) ? ic_mem_data_valid : dc_mem_data_valid;
  endfunction

  function automatic logic [B-1:0] data_of(input int p);
    return (p == 0) ? ic_mem_data_in : dc_mem_data_in;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_pend[p] = 1'b0;
      m_data[p] = '0;
    end
    m_last = 1;
  endtask

  task automatic set_req(input int p, input logic [A-1:0] a, input logic w, input logic [W-1:0] d);
    if (p == 0) begin
      ic_mem_req = 1'b1; ic_mem_address = a; ic_mem_wr_en = w; ic_mem_data_out = d;
    end else begin
      dc_mem_req = 1'b1; dc_mem_address = a; dc_mem_wr_en = w; dc_mem_data_out = d;
    end
    if (!m_pend[p]) begin
      m_pend[p]  = 1'b1;
      m_addr[p]  = a;
      m_wr[p]    = w;
      m_wdata[p] = d;
    end
  endtask

  task automatic clr_req();
    ic_mem_req = 1'b0;
    dc_mem_req = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_bus_req"}, bus_req, 1'b0);
    check_val({tag, "_ic_valid"}, ic_mem_data_valid, 1'b0);
    check_val({tag, "_dc_valid"}, dc_mem_data_valid, 1'b0);
  endtask

  // Wait for the next bus request, act as the memory and check the completion.
  // beat_mode 1 returns beat k = k, otherwise random beats.
  task automatic serve(input int rdly, input int maxgap, input int wdly,
                       input int beat_mode, output int resp_cyc);
    int           n;
    int           exp_p, oth;
    logic [A-1:0] exp_addr;
    logic [W-1:0] bv;
    logic [B-1:0] line;
    n = 0;
    resp_cyc = -1;
    while (!bus_req && n < 30) begin
      step();
      n++;
    end
    if (!bus_req) begin
      check_val("bus_req_timeout", 1'b0, 1'b1);
      return;
    end
    exp_p    = (m_pend[0] && m_pend[1]) ? (1 - m_last) : (m_pend[0] ? 0 : 1);
    oth      = 1 - exp_p;
    exp_addr = m_wr[exp_p] ? m_addr[exp_p] : (m_addr[exp_p] & ~64'h3F);
    check_val("bus_addr", bus_addr, exp_addr);
    check_val("bus_wr", bus_wr, m_wr[exp_p]);
    if (m_wr[exp_p]) check_val("bus_wdata", bus_wdata, m_wdata[exp_p]);
    for (int i = 0; i < rdly; i++) begin
      step();
      check_val("bus_req_hold", bus_req, 1'b1);
    end
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    check_val("bus_req_drop", bus_req, 1'b0);
    line = '0;
    if (!m_wr[exp_p]) begin
      for (int k = 0; k < N; k++) begin
        repeat ($urandom_range(maxgap, 0)) step();
        bv = (beat_mode == 1) ? W'(k) : {$urandom, $urandom};
        line[k*W +: W] = bv;
        bus_rvalid = 1'b1;
        bus_rdata  = bv;
        step();
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
      end
      m_data[exp_p] = line;
    end else begin
      repeat (wdly) step();
      bus_wack = 1'b1;
      step();
      bus_wack = 1'b0;
    end
    check_val("valid_owner", valid_of(exp_p), 1'b1);
    check_val("valid_other", valid_of(oth), 1'b0);
    check_val("data_owner", data_of(exp_p), m_data[exp_p]);
    check_val("data_other", data_of(oth), m_data[oth]);
    resp_cyc = cyc;
    m_pend[exp_p] = 1'b0;
    m_last = exp_p;
    m_done[exp_p]++;
    $display("txn port=%0d wr=%0d addr=%h cycle=%0d", exp_p, m_wr[exp_p], m_addr[exp_p], cyc);
    step();
    check_val("valid_single", valid_of(exp_p), 1'b0);
    check_val("idle_gap", bus_req, 1'b0);
  endtask

  initial begin
    int t0, rc, iss0, vc0, vd0, sel;
    m_done[0] = 0;
    m_done[1] = 0;
    model_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    // Reset state
    check_val("rst_bus_addr", bus_addr, '0);
    check_val("rst_bus_wr", bus_wr, 1'b0);
    check_val("rst_bus_wdata", bus_wdata, '0);
    check_val("rst_ic_data", ic_mem_data_in, '0);
    check_val("rst_dc_data", dc_mem_data_in, '0);
    check_idle_zero("rst");

    // I-cache read, exact timeline
    set_req(0, 64'h1234_5678, 1'b0, '0);
    step();
    clr_req();
    t0 = cyc;
    serve(0, 0, 0, 1, rc);
    check_val("read_latency", 32'(rc - t0), 32'd10);
    check_val("ic_low_beat", ic_mem_data_in[63:0], 64'd0);
    check_val("ic_high_beat", ic_mem_data_in[511:448], 64'd7);

    // Simultaneous requests after reset: I-cache first, then D-cache
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    set_req(0, 64'h0000_2000, 1'b0, '0);
    set_req(1, 64'h0000_3000, 1'b0, '0);
    step();
    clr_req();
    vc0 = ic_vcnt;
    vd0 = dc_vcnt;
    serve($urandom_range(2, 0), 1, 0, 0, rc);
    serve($urandom_range(2, 0), 1, 0, 0, rc);
    check_val("tie_ic_pulses", 32'(ic_vcnt - vc0), 32'd1);
    check_val("tie_dc_pulses", 32'(dc_vcnt - vd0), 32'd1);

    // D-cache write
    set_req(1, 64'h1008, 1'b1, 64'hDEAD_BEEF);
    step();
    clr_req();
    serve(3, 0, 2, 0, rc);

    // Duplicate request while pending is dropped
    iss0 = issues;
    set_req(0, 64'h0000_4040, 1'b0, '0);
    step();
    clr_req();
    set_req(0, 64'h0000_9980, 1'b0, '0);
    step();
    clr_req();
    serve(1, 0, 0, 0, rc);
    repeat (5) step();
    check_val("dup_one_issue", 32'(issues - iss0), 32'd1);

    // Reset in the middle of a read
    set_req(0, 64'h0000_7700, 1'b0, '0);
    step();
    clr_req();
    for (int n = 0; n < 10 && !bus_req; n++) step();
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus_rvalid = 1'b1;
      bus_rdata  = {$urandom, $urandom};
      step();
    end
    bus_rvalid = 1'b0;
    vc0 = ic_vcnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    check_val("mid_rst_bus_addr", bus_addr, '0);
    check_val("mid_rst_ic_data", ic_mem_data_in, '0);
    check_val("mid_rst_dc_data", dc_mem_data_in, '0);
    check_idle_zero("mid_rst");
    for (int k = 5; k < N; k++) begin
      bus_rvalid = 1'b1;
      bus_rdata  = {$urandom, $urandom};
      step();
    end
    bus_rvalid = 1'b0;
    step();
    check_val("aborted_no_valid", 32'(ic_vcnt - vc0), 32'd0);
    check_idle_zero("aborted");
    set_req(0, 64'h0000_8888, 1'b0, '0);
    step();
    clr_req();
    serve(0, 2, 0, 0, rc);

    // Randomized traffic with beat gaps and stray bus pulses while idle
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(2, 0) == 0) begin
        bus_rvalid = 1'b1;
        bus_wack   = 1'b1;
        bus_rdata  = {$urandom, $urandom};
        step();
        bus_rvalid = 1'b0;
        bus_wack   = 1'b0;
        step();
        check_idle_zero("stray");
      end
      sel = $urandom_range(3, 1);
      if (sel[0]) set_req(0, {$urandom, $urandom}, 1'($urandom_range(1, 0)), {$urandom, $urandom});
      if (sel[1]) set_req(1, {$urandom, $urandom}, 1'($urandom_range(1, 0)), {$urandom, $urandom});
      step();
      clr_req();
      if (sel[0] && $urandom_range(1, 0) == 1) begin
        set_req(0, {$urandom, $urandom}, 1'($urandom_range(1, 0)), {$urandom, $urandom});
        step();
        clr_req();
      end
      while (m_pend[0] || m_pend[1]) begin
        serve($urandom_range(3, 0), 3, $urandom_range(3, 0), 0, rc);
        if (rc < 0) break;
      end
    end

    check_val("ic_total_pulses", 32'(ic_vcnt), 32'(m_done[0]));
    check_val("dc_total_pulses", 32'(dc_vcnt), 32'(m_done[1]));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter between the instruction cache and the data cache on one side and the external 64-bit memory bus on the other. It latches the one-cycle `mem_req` pulses each cache issues, grants the bus round-robin, and assembles a read as eight 64-bit beats into one 512-bit line. It returns the line to the owning cache with a one-cycle `mem_data_valid` pulse. Single-beat 64-bit writes are forwarded to the bus and acknowledged with the same pulse.

## Interface
- `WIDTH`, 64: bus beat and write-data width.
- `BLOCKSZ`, 512: cache line width; must equal `BEATS*WIDTH`.
- `BEATS`, 8: beats per line read.
- `ADDRESSSIZE`, 64: address width.

One clock; reset is synchronous and active-high.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ic_mem_req`  in  1  I-cache request pulse.
- `ic_mem_address`  in  ADDRESSSIZE  I-cache request address.
- `ic_mem_wr_en`  in  1  I-cache request is a write.
- `ic_mem_data_out`  in  WIDTH  I-cache write data.
- `ic_mem_data_in`  out  BLOCKSZ  line returned to the I-cache.
- `ic_mem_data_valid`  out  1  one-cycle completion pulse to the I-cache.
- `dc_*`  same six ports as `ic_*`, for the D-cache.
- `bus_req`  out  1  bus request valid.
- `bus_addr`  out  ADDRESSSIZE  bus address.
- `bus_wr`  out  1  bus request is a write.
- `bus_wdata`  out  WIDTH  bus write data.
- `bus_ready`  in  1  bus accepts the request this cycle.
- `bus_rdata`  in  WIDTH  read beat.
- `bus_rvalid`  in  1  read beat valid.
- `bus_wack`  in  1  write acknowledged.

## Operation
- **Per-port capture register:**
  - Holds `pend`, `addr`, `wr` and `wdata`.
  - A `*_mem_req` high on an edge while `pend`=0 sets `pend` and latches the address, write flag and data.
  - A `*_mem_req` while `pend`=1 is dropped.
  - `pend` clears on the edge that ends that port's RESPOND cycle. A new request arriving on that same edge is captured: set wins.
- **Arbitration:**
  - Evaluated only in IDLE.
  - If only one port is pending, grant it.
  - If both are pending, grant the port not served last (`last_grant` register). After reset `last_grant`=D-cache, so the I-cache wins the first tie.
- **Read addresses:** `bus_addr` = captured address with bits [5:0] forced to 0. Write addresses pass through unaligned.
- **States:**
  - IDLE: if any port is pending, go to ISSUE and latch the owner.
  - ISSUE: hold `bus_req`=1 with stable `bus_addr`/`bus_wr`/`bus_wdata`. On `bus_ready`=1, go to RDATA (read) or WACK (write).
  - RDATA: each `bus_rvalid` beat k (0-based, 3-bit counter) is written into line bits [64k+63:64k]. The beat with k=BEATS-1 goes to RESPOND.
  - WACK: `bus_wack`=1 goes to RESPOND.
  - RESPOND: drive the owner's `*_mem_data_valid`=1 for exactly one cycle, update `last_grant`, go to IDLE.
- **Returned data:**
  - On a read, `*_mem_data_in` loads the assembled line and holds it until that port's next read completes.
  - Writes leave `*_mem_data_in` unchanged.
  - The non-owner port's outputs never change.
- **Ignored bus inputs:** `bus_rvalid` outside RDATA and `bus_wack` outside WACK are ignored.
- **Reset:** at any time returns the block to IDLE, clears both `pend` bits and the beat counter, and drives all outputs to 0. Beats of an abandoned transfer are ignored.

## Timing
- **Reset values:**
  - `bus_req`, `bus_wr`, `bus_addr`, `bus_wdata` = 0.
  - `ic_/dc_mem_data_valid` = 0.
  - `ic_/dc_mem_data_in` = 0.
  - State IDLE; `last_grant` = D-cache.
- **Read timeline:** `*_mem_req` sampled at edge 0.
  - `pend` visible in cycle 1 (IDLE).
  - ISSUE with `bus_req`=1 in cycle 2.
  - If `bus_ready`=1 in cycle 2, RDATA starts in cycle 3.
  - With back-to-back beats in cycles 3–10, RESPOND (`data_valid`=1, line valid) occurs in cycle 11.
  - Back in IDLE in cycle 12.
- **Write timeline:** `bus_wack` in cycle n gives RESPOND in cycle n+1.
- **Bus handshake:** `bus_req` drops in the cycle after the one where `bus_ready`=1. It is never high outside ISSUE.
- **Gaps:** gaps between beats are allowed; the counter advances only on `bus_rvalid`.
- **Back-to-back grants:** IDLE always lasts at least one cycle between grants.

## Test plan
- **I-cache read:**
  - Stimulus: `ic_mem_req` with address 0x1234_5678. Bus: `bus_ready` immediately, beats 0x0..0x7 back-to-back.
  - Required: `bus_addr`=0x1234_5640. `ic_mem_data_valid` pulses once in cycle 11. `ic_mem_data_in[63:0]`=0, `[511:448]`=7. `dc_*` outputs unchanged.
- **Simultaneous requests after reset:**
  - Stimulus: I-cache and D-cache requests in the same cycle.
  - Required: the I-cache is served first, then the D-cache. Each gets exactly one `data_valid` pulse. The D-cache `bus_req` starts at least one IDLE cycle after the I-cache RESPOND.
- **D-cache write:**
  - Stimulus: `dc_mem_req` with wr=1, addr 0x1008, data 0xDEADBEEF. `bus_ready` after 3 cycles, `bus_wack` 2 cycles later.
  - Required: `bus_wr`=1, `bus_addr`=0x1008, `bus_wdata`=0xDEADBEEF. `dc_mem_data_valid` pulses once. `dc_mem_data_in` unchanged.
- **Beat gaps and stray inputs:**
  - Stimulus: read with random 0–3 cycle gaps between beats. Stray `bus_rvalid`/`bus_wack` pulses while IDLE.
  - Required: the line is assembled correctly and the stray pulses have no effect.
- **Reset mid-read:**
  - Stimulus: assert `rst` after beat 4. Deliver the remaining beats, then issue a new read.
  - Required: no `data_valid` from the aborted read. All outputs are 0. The new read returns a correct line.
- **Duplicate request while pending:**
  - Stimulus: second `ic_mem_req` while the I-cache is pending.
  - Required: dropped; one bus transaction only.
